// File: rtl/ledtest_pio_pkg.sv
// ledtest_pio_pkg: shared constants for the LED output PIO.
// Register map and bus geometry used by the top level and the bus interface.
package ledtest_pio_pkg;
  localparam int BUS_W = 32;
  localparam int READ_LATENCY = 1;
  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLR   = 2'd2;
  localparam logic [1:0] ADDR_BLINK = 2'd3;
endpackage

// File: rtl/ledtest_pio_if.sv
// ledtest_pio_if: Avalon-MM slave bus bundle for the LED output PIO.
// Master drives select/strobe/data; slave returns registered readdata.
interface ledtest_pio_if;
  import ledtest_pio_pkg::*;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [BUS_W-1:0] writedata;
  logic [BUS_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_blink_prescaler.sv
// pio_blink_prescaler: free-running divider producing the LED blink phase.
// Phase toggles once every BLINK_DIV clocks; restarts at 0 on reset.
module pio_blink_prescaler #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset_n,
  output logic phase
);
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (cnt_q == TERM) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
endmodule

// File: rtl/ledtest_pio_out.sv
// ledtest_pio_out: Avalon-MM output PIO driving LEDs with per-bit blink.
// Data register with set/clear strobes, blink mask, 1-cycle read latency.
module ledtest_pio_out
  import ledtest_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BLINK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  ledtest_pio_if.slave     bus,
  output logic [WIDTH-1:0] out_port
);
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [BUS_W-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] wdata;
  logic             wr;
  logic             phase;

  pio_blink_prescaler #(
    .BLINK_DIV(BLINK_DIV)
  ) u_presc (
    .clk    (clk),
    .reset_n(reset_n),
    .phase  (phase)
  );

  assign wr    = bus.chipselect & ~bus.write_n;
  assign wdata = bus.writedata[WIDTH-1:0];

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    if (wr) begin
      unique case (bus.address)
        ADDR_DATA:  data_d = wdata;
        ADDR_SET:   data_d = data_q | wdata;
        ADDR_CLR:   data_d = data_q & ~wdata;
        ADDR_BLINK: mask_d = wdata;
      endcase
    end
  end

  // Read mux samples pre-write state, so a write is visible next cycle.
  always_comb begin
    rdata_d = '0;
    if (bus.address == ADDR_BLINK) rdata_d[WIDTH-1:0] = mask_q;
    else                           rdata_d[WIDTH-1:0] = data_q;
  end

  assign out_d = data_q & (~mask_q | {WIDTH{phase}});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q  <= '0;
      mask_q  <= '0;
      out_q   <= '0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      mask_q  <= mask_d;
      out_q   <= out_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign out_port     = out_q;
endmodule

// File: tb/tb_ledtest_pio_out.sv
// tb_ledtest_pio_out: scoreboard bench for the LED output PIO.
// Directed plan sequences plus random traffic against a behavioural model.
module tb_ledtest_pio_out;
  localparam int W  = 8;
  localparam int BD = 4;

  typedef struct {
    logic [31:0]  rd;
    logic [W-1:0] out;
    string        tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] out_port;

  ledtest_pio_if bus ();

  ledtest_pio_out #(
    .WIDTH    (W),
    .BLINK_DIV(BD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // behavioural model state
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_mask = '0;
  int           m_edges = 0;

  task automatic cyc(input logic rst, input logic cs, input logic wn,
                     input logic [1:0] a, input logic [31:0] wd,
                     input string tag);
    exp_t e;
    logic ph;
    logic [W-1:0] w;
    @(negedge clk);
    reset_n        = rst;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = wd;
    e.tag = tag;
    if (!rst) begin
      e.rd = '0;
      e.out = '0;
      m_data = '0;
      m_mask = '0;
      m_edges = 0;
    end else begin
      ph = ((m_edges / BD) % 2) == 1;
      e.rd = (a == 2'd3) ? 32'(m_mask) : 32'(m_data);
      e.out = ph ? m_data : (m_data & ~m_mask);
      w = wd[W-1:0];
      if (cs && !wn) begin
        case (a)
          2'd0: m_data = w;
          2'd1: m_data = m_data | w;
          2'd2: m_data = m_data & ~w;
          default: m_mask = w;
        endcase
      end
      m_edges++;
    end
    q.push_back(e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input string t);
    cyc(1'b1, 1'b1, 1'b0, a, d, t);
  endtask

  task automatic rd(input logic [1:0] a, input string t);
    cyc(1'b1, 1'b0, 1'b1, a, 32'hDEAD_BEEF, t);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (bus.readdata !== e.rd) begin
          n_err++;
          $display("FAIL %s readdata: got %h want %h", e.tag, bus.readdata, e.rd);
        end
        n_chk++;
        if (out_port !== e.out) begin
          n_err++;
          $display("FAIL %s out_port: got %h want %h", e.tag, out_port, e.out);
        end
      end
    end
  end

  initial begin : stim
    int budget;
    reset_n = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.address = 2'd0;
    bus.writedata = '0;
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 2'd0, 32'hFF, "reset_wr");
    rd(2'd0, "post_reset");
    wr(2'd0, 32'h5A, "wr_5a");
    rd(2'd0, "rd_5a");
    wr(2'd1, 32'h81, "set_81");
    rd(2'd0, "rd_db");
    wr(2'd2, 32'h0F, "clr_0f");
    rd(2'd0, "rd_d0");
    rd(2'd0, "rd_d0b");
    wr(2'd0, 32'hFFFF_FF3C, "upper");
    rd(2'd0, "rd_3c");
    cyc(1'b1, 1'b1, 1'b0, 2'd2, 32'h00, "csw_clr0");
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h11, "nocs");
    rd(2'd0, "rd_nocs");
    wr(2'd0, 32'hFF, "wr_ff");
    wr(2'd3, 32'h0F, "mask_0f");
    for (int i = 0; i < 12; i++) rd(2'd3, "blink");
    rd(2'd0, "b2b_0");
    rd(2'd3, "b2b_3");
    wr(2'd0, 32'h33, "rdw_old");
    rd(2'd0, "rdw_new");
    wr(2'd0, 32'hFF, "wr_ff2");
    for (int i = 0; i < 6; i++) rd(2'd0, "to_phase1");
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 0, "mid_rst");
    for (int i = 0; i < 10; i++) rd(2'd0, "after_rst");
    wr(2'd0, 32'hA5, "wr_a5");
    wr(2'd3, 32'hF0, "mask_f0");
    for (int i = 0; i < 10; i++) rd(2'd0, "blink2");
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom),
          2'($urandom), $urandom, "rand");
    end
    rd(2'd0, "drain");
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
